// File: rtl/iecdrv_bitmem_arb.sv
// Byte RAM shared by a byte port (A) and a B_WIDTH-bit slice port (B), round-robin arbitrated.
// Latency: A write acks at grant+1; reads and B writes (read-modify-write) ack at grant+2.
// Backpressure: req is held until the one-cycle ack; a losing port waits in IDLE with no side effect.
// Optional feature macro: IECDRV_BITMEM_PARITY_EN adds an even-parity bit per byte and a_perr/b_perr reporting.
module iecdrv_bitmem_arb #(
   parameter int ADDRWIDTH = 13,
   parameter int B_WIDTH   = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         a_req,
   input  logic                         a_we,
   input  logic [ADDRWIDTH-1:0]         a_addr,
   input  logic [7:0]                   a_din,
   output logic                         a_ack,
   output logic [7:0]                   a_dout,
   output logic                         a_perr,
   input  logic                         b_req,
   input  logic                         b_we,
   input  logic [ADDRWIDTH+$clog2(8/B_WIDTH)-1:0] b_addr,
   input  logic [B_WIDTH-1:0]           b_din,
   output logic                         b_ack,
   output logic [B_WIDTH-1:0]           b_dout,
   output logic                         b_perr
);

   localparam int LANES = 8 / B_WIDTH;
   localparam int LSEL  = $clog2(LANES);
   localparam int LW    = (LSEL > 0) ? LSEL : 1;
   localparam int DEPTH = 1 << ADDRWIDTH;
`ifdef IECDRV_BITMEM_PARITY_EN
   localparam int RW = 9;
`else
   localparam int RW = 8;
`endif

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RSP, S_MRG} state_t;

   state_t               state_q, state_d;
   logic                 sel_b_q, sel_b_d;
   logic                 we_q, we_d;
   logic                 last_b_q, last_b_d;
   logic [ADDRWIDTH-1:0] addr_q, addr_d;
   logic [7:0]           din_q, din_d;
   logic [LW-1:0]        lane_q, lane_d;
   logic [7:0]           a_dout_q, a_dout_d;
   logic [B_WIDTH-1:0]   b_dout_q, b_dout_d;

   logic [ADDRWIDTH-1:0] b_byte;
   logic [LW-1:0]        b_lane;
   logic                 grant_b;
   logic                 ram_we, ram_re;
   logic [7:0]           wbyte, merged;
   logic [RW-1:0]        ram_wdata;
   logic [RW-1:0]        rdata_q;
   logic                 perr_raw;
   logic [RW-1:0]        mem [DEPTH];

   // Split the slice address into byte address and lane; an 8-bit slice has no lane field.
   generate
      if (LSEL > 0) begin : g_lane
         assign b_byte = b_addr[ADDRWIDTH+LSEL-1:LSEL];
         assign b_lane = b_addr[LSEL-1:0];
      end else begin : g_nolane
         assign b_byte = b_addr;
         assign b_lane = '0;
      end
   endgenerate

   // On a tie, the port that did not win last time gets the grant.
   assign grant_b = b_req && (!a_req || !last_b_q);

   // Read byte with the captured lane replaced by the B write data.
   always_comb begin
      merged = rdata_q[7:0];
      merged[int'(lane_q)*B_WIDTH +: B_WIDTH] = din_q[B_WIDTH-1:0];
   end

   // Write data goes out with a freshly generated parity bit when parity is enabled.
   always_comb begin
      wbyte = (state_q == S_MRG) ? merged : din_q;
`ifdef IECDRV_BITMEM_PARITY_EN
      ram_wdata = {^wbyte, wbyte};
      perr_raw  = (^rdata_q[7:0]) ^ rdata_q[8];
`else
      ram_wdata = wbyte;
      perr_raw  = 1'b0;
`endif
   end

   // Sequencer: next state, request capture, RAM strobes and response registers.
   always_comb begin
      state_d  = state_q;
      sel_b_d  = sel_b_q;
      we_d     = we_q;
      last_b_d = last_b_q;
      addr_d   = addr_q;
      din_d    = din_q;
      lane_d   = lane_q;
      a_dout_d = a_dout_q;
      b_dout_d = b_dout_q;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      a_ack    = 1'b0;
      b_ack    = 1'b0;
      a_perr   = 1'b0;
      b_perr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               sel_b_d  = grant_b;
               last_b_d = grant_b;
               if (grant_b) begin
                  we_d   = b_we;
                  addr_d = b_byte;
                  lane_d = b_lane;
                  din_d  = '0;
                  din_d[B_WIDTH-1:0] = b_din;
                  state_d = S_RD;
               end else begin
                  we_d    = a_we;
                  addr_d  = a_addr;
                  lane_d  = '0;
                  din_d   = a_din;
                  state_d = a_we ? S_WR : S_RD;
               end
            end
         end
         S_WR: begin
            ram_we  = 1'b1;
            a_ack   = 1'b1;
            state_d = S_IDLE;
         end
         S_RD: begin
            ram_re  = 1'b1;
            state_d = (we_q && sel_b_q) ? S_MRG : S_RSP;
         end
         S_RSP: begin
            if (sel_b_q) begin
               b_ack    = 1'b1;
               b_perr   = perr_raw;
               b_dout_d = rdata_q[int'(lane_q)*B_WIDTH +: B_WIDTH];
            end else begin
               a_ack    = 1'b1;
               a_perr   = perr_raw;
               a_dout_d = rdata_q[7:0];
            end
            state_d = S_IDLE;
         end
         S_MRG: begin
            ram_we  = 1'b1;
            b_ack   = 1'b1;
            b_perr  = perr_raw;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and response registers; "last granted" starts at B so A wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         sel_b_q  <= 1'b0;
         we_q     <= 1'b0;
         last_b_q <= 1'b1;
         addr_q   <= '0;
         din_q    <= '0;
         lane_q   <= '0;
         a_dout_q <= '0;
         b_dout_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_b_q  <= sel_b_d;
         we_q     <= we_d;
         last_b_q <= last_b_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         lane_q   <= lane_d;
         a_dout_q <= a_dout_d;
         b_dout_q <= b_dout_d;
      end
   end

   // Single-port RAM with registered read data; contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) mem[addr_q] <= ram_wdata;
      if (ram_re) rdata_q <= mem[addr_q];
   end

   assign a_dout = a_dout_q;
   assign b_dout = b_dout_q;

endmodule

// File: doc/iecdrv_bitmem_arb.md
# iecdrv_bitmem_arb

Single-clock dual-width drive memory: one byte-wide RAM shared by a byte port (A, CPU/loader side) and a narrow sub-byte port (B, GCR bit-stream side). Round-robin arbitration and a read-modify-write sequencer let port B read and write B_WIDTH-bit slices without a second RAM or per-bit RAMs. Sits between the drive CPU/QNICE loader and the disk-track shifter, inside the drive clock domain.

## Interface
Parameters:
- ADDRWIDTH, 13, byte address width; depth 2^ADDRWIDTH bytes
- B_WIDTH, 1, port-B slice width; legal values 1, 2, 4, 8
- LANES (derived, not overridable) = 8/B_WIDTH; LSEL = log2(LANES)

Ports:
- clk  in  1  sole clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  port-A request, held until a_ack
- a_we  in  1  1 = write, 0 = read; sampled at grant
- a_addr  in  ADDRWIDTH  byte address; sampled at grant
- a_din  in  8  write data; sampled at grant
- a_ack  out  1  one-cycle completion pulse
- a_dout  out  8  read data; loaded on read ack, held otherwise
- a_perr  out  1  parity error, pulses with a_ack
- b_req, b_we  in  1  as port A
- b_addr  in  ADDRWIDTH+LSEL  slice address; low LSEL bits = lane
- b_din  in  B_WIDTH  slice write data
- b_ack  out  1  one-cycle completion pulse
- b_dout  out  B_WIDTH  slice read data; loaded on read ack, held otherwise
- b_perr  out  1  parity error, pulses with b_ack

## Operation
- RAM: single-port, synchronous read, registered output, not reset (contents undefined until written).
- Lane k occupies byte bits [k*B_WIDTH+B_WIDTH-1 : k*B_WIDTH]; lane 0 = LSBs.
- States: IDLE, WR, RD, RSP, MRG.
- IDLE: if any req, grant one, capture we/addr/din/lane. Both requesting: grant port not granted last; after reset "last" = B, so A wins first tie. Next state: A write -> WR; any read or B write -> RD.
- WR: write a_din to RAM, a_ack=1 -> IDLE.
- RD: RAM read at captured byte address -> RSP for reads, MRG for B writes.
- RSP: a_dout <= RAM byte or b_dout <= selected lane; ack granted port -> IDLE.
- MRG: replace captured lane of RAM byte with b_din, write back, b_ack=1 -> IDLE. B_WIDTH=8 still uses RMW path (uniform timing).
- Only one access in flight; the other port's req waits in IDLE with no side effect.
- Req high in IDLE the cycle after ack = new request (back-to-back allowed). Dropping req before ack is illegal; behaviour: access completes anyway, ack still pulses.
- Reset mid-operation: state -> IDLE, uncommitted B merge dropped, RAM bytes already written keep value.

## Timing
- Grant cycle = IDLE cycle with req high (call it T).
- A write: a_ack at T+1, RAM updated at end of T+1.
- A read / B read: ack at T+2, dout valid from T+3 (registered on ack edge) and held.
- B write: b_ack at T+2, RAM updated at end of T+2.
- Next grant no earlier than cycle after ack; sustained A-write rate 1 per 2 cycles, others 1 per 3.
- Read returns data of any write completed in an earlier cycle (no stale data).
- Reset values: a_ack, b_ack, a_perr, b_perr = 0; a_dout = 0x00; b_dout = 0; state IDLE; last = B.

## Configuration
- IECDRV_BITMEM_PARITY_EN defined: RAM 9 bits wide; bit 8 = even parity of byte, generated on every write (WR and MRG). On RSP and MRG, recomputed parity of read byte compared; mismatch pulses a_perr/b_perr with the ack. MRG with bad parity still writes back with fresh parity.
- Not defined: RAM 8 bits; a_perr, b_perr tied 0; timing identical.

## Test plan
- Reset: reset_n low mid-B-write -> after release all outputs 0, state IDLE, target byte unchanged from prior value.
- A write 0xA5 @0x010, A read @0x010 -> a_ack at T+1 then T+2, a_dout=0xA5.
- B_WIDTH=1: after A write 0x00 @0x010, B writes 1 to slice addrs 0x080,0x082,0x087 -> A read @0x010 returns 0x85; B read 0x081 returns 0.
- B_WIDTH=2: A write 0xFF @0x003, B write 2'b00 to lane 2 (b_addr=0x00E) -> A read 0xCF.
- Contention: a_req and b_req high together from reset, both held -> grants A, B, A, B; each ack exactly one pulse; no lost writes.
- Parity (macro on): write 0x3C, backdoor flip stored bit 0 -> A read returns 0x3D with a_perr=1 coincident with a_ack; macro off -> a_perr stays 0.
